// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS main control unit.
// Sequences each instruction through FETCH/DECODE/execute/memory/writeback
// states and drives the datapath enables and mux selects as Moore decodes of
// the registered state (branch pcWrite additionally follows the ALU zero flag).
// Optional feature: define MC_CTRL_BNE_EN to add the BNEEX state (op 000101).
module mc_ctrl_fsm #(
    parameter logic [3:0]      RESET_STATE = 4'd0,   // FETCH; must stay FETCH
    localparam int unsigned    STATE_W     = 4,
    localparam int unsigned    OP_W        = 6,
    localparam int unsigned    ALUOP_W     = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    input  logic [OP_W-1:0]    funct,
    input  logic               zero,
    output logic [ALUOP_W-1:0] aluOp,
    output logic               aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic [1:0]         pcSrc,
    output logic               pcWrite,
    output logic               iorD,
    output logic               memWrite,
    output logic               irWrite,
    output logic               regDst,
    output logic               memToReg,
    output logic               regWrite,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12
    } state_t;

    // Datapath control bundle produced by the decode process
    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic [1:0]         pc_src;
        logic               pc_write;
        logic               ior_d;
        logic               mem_write;
        logic               ir_write;
        logic               reg_dst;
        logic               mem_to_reg;
        logic               reg_write;
    } ctrl_t;

    // Opcodes
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_BNE_EN
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
`endif

    // R-type funct codes
    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [ALUOP_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 3'b111;

    // Mux select encodings
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;
    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JMP  = 2'b10;

    state_t state_q;
    state_t next_state;
    logic   funct_invalid_q;
    logic   funct_invalid_d;
    ctrl_t  ctrl;

    // State register and funct-invalid flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= state_t'(RESET_STATE);
            funct_invalid_q <= 1'b0;
        end else begin
            state_q         <= next_state;
            funct_invalid_q <= funct_invalid_d;
        end
    end

    // Next-state and control decode; everything inactive while reset is high
    always_comb begin
        ctrl            = '0;
        next_state      = S_FETCH;
        funct_invalid_d = funct_invalid_q;

        case (state_q)
            S_FETCH: begin
                ctrl.ior_d     = 1'b0;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.pc_write  = 1'b1;
                next_state     = S_DECODE;
            end
            S_DECODE: begin
                // Precompute branch target into ALUOut
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMMSH;
                ctrl.alu_op    = ALU_ADD;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_RTYPEEX;
                    OP_BEQ:       next_state = S_BEQEX;
                    OP_ADDI:      next_state = S_ADDIEX;
                    OP_J:         next_state = S_JEX;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       next_state = S_BNEEX;
`endif
                    default:      next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                next_state     = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                ctrl.ior_d = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                next_state      = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.ior_d     = 1'b1;
                ctrl.mem_write = 1'b1;
                next_state     = S_FETCH;
            end
            S_RTYPEEX: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_REG;
                funct_invalid_d = 1'b0;
                case (funct)
                    FN_ADD:  ctrl.alu_op = ALU_ADD;
                    FN_SUB:  ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_SLT:  ctrl.alu_op = ALU_SLT;
                    default: begin
                        ctrl.alu_op     = ALU_AND;
                        funct_invalid_d = 1'b1;
                    end
                endcase
                next_state = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                // Unsupported funct suppresses the register write
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_write  = ~funct_invalid_q;
                next_state      = S_FETCH;
            end
            S_BEQEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = PCSRC_OUT;
                ctrl.pc_write  = zero;
                next_state     = S_FETCH;
            end
`ifdef MC_CTRL_BNE_EN
            S_BNEEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = PCSRC_OUT;
                ctrl.pc_write  = ~zero;
                next_state     = S_FETCH;
            end
`endif
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
                next_state     = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_write  = 1'b1;
                next_state      = S_FETCH;
            end
            S_JEX: begin
                ctrl.pc_src   = PCSRC_JMP;
                ctrl.pc_write = 1'b1;
                next_state    = S_FETCH;
            end
            default: begin
                // Illegal code: stay inactive and recover through FETCH
                ctrl       = '0;
                next_state = S_FETCH;
            end
        endcase

        // The flag only lives for the duration of one R-type instruction
        if (next_state == S_FETCH) begin
            funct_invalid_d = 1'b0;
        end

        if (reset) begin
            ctrl = '0;
        end
    end

    // Drive ports from the decoded bundle
    assign aluOp    = ctrl.alu_op;
    assign aluSrcA  = ctrl.alu_src_a;
    assign aluSrcB  = ctrl.alu_src_b;
    assign pcSrc    = ctrl.pc_src;
    assign pcWrite  = ctrl.pc_write;
    assign iorD     = ctrl.ior_d;
    assign memWrite = ctrl.mem_write;
    assign irWrite  = ctrl.ir_write;
    assign regDst   = ctrl.reg_dst;
    assign memToReg = ctrl.mem_to_reg;
    assign regWrite = ctrl.reg_write;
    assign state    = reset ? STATE_W'(0) : STATE_W'(state_q);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: table-driven, scoreboarded bench for mc_ctrl_fsm.
// Honors MC_CTRL_BNE_EN to select the expected op 000101 behaviour.
module tb_mc_ctrl_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] aluOp;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic       pcWrite;
    logic       iorD;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic [3:0] state;

    mc_ctrl_fsm dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .funct    (funct),
        .zero     (zero),
        .aluOp    (aluOp),
        .aluSrcA  (aluSrcA),
        .aluSrcB  (aluSrcB),
        .pcSrc    (pcSrc),
        .pcWrite  (pcWrite),
        .iorD     (iorD),
        .memWrite (memWrite),
        .irWrite  (irWrite),
        .regDst   (regDst),
        .memToReg (memToReg),
        .regWrite (regWrite),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output vector, one per cycle
    typedef struct packed {
        logic [3:0] state;
        logic [2:0] alu_op;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       ior_d;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } obs_t;

    // One instruction: inputs, expected state walk, and the instruction-specific outputs
    typedef struct {
        logic [5:0]      op;
        logic [5:0]      funct;
        logic            zero;
        int              len;
        logic [4:0][3:0] st;
        logic [2:0]      ex_alu_op;
        logic            wb_reg_write;
        logic            br_pc_write;
    } vec_t;

    localparam int NVEC = 16;
    vec_t  vecs [NVEC];
    obs_t  exp_q [$];
    string tag_q [$];
    int    n_tests;
    int    n_fail;

    obs_t  mon_act;
    obs_t  mon_exp;
    string mon_tag;

    function automatic vec_t mkv(input logic [5:0] o, input logic [5:0] f, input logic z,
                                 input int len, input logic [3:0] s0, input logic [3:0] s1,
                                 input logic [3:0] s2, input logic [3:0] s3, input logic [3:0] s4,
                                 input logic [2:0] exa, input logic wbr, input logic brp);
        vec_t v;
        v.op = o; v.funct = f; v.zero = z; v.len = len;
        v.st[0] = s0; v.st[1] = s1; v.st[2] = s2; v.st[3] = s3; v.st[4] = s4;
        v.ex_alu_op = exa; v.wb_reg_write = wbr; v.br_pc_write = brp;
        return v;
    endfunction

    // Expected outputs for a given state code, from the state table
    function automatic obs_t spec_out(input logic [3:0] s, input vec_t v);
        obs_t o;
        o = '0;
        o.state = s;
        case (s)
            4'd0:  begin o.alu_op = 3'b010; o.src_b = 2'b01; o.pc_write = 1'b1; o.ir_write = 1'b1; end
            4'd1:  begin o.alu_op = 3'b010; o.src_b = 2'b11; end
            4'd2:  begin o.alu_op = 3'b010; o.src_a = 1'b1; o.src_b = 2'b10; end
            4'd3:  begin o.ior_d = 1'b1; end
            4'd4:  begin o.mem_to_reg = 1'b1; o.reg_write = 1'b1; end
            4'd5:  begin o.ior_d = 1'b1; o.mem_write = 1'b1; end
            4'd6:  begin o.src_a = 1'b1; o.alu_op = v.ex_alu_op; end
            4'd7:  begin o.reg_dst = 1'b1; o.reg_write = v.wb_reg_write; end
            4'd8, 4'd12: begin
                o.src_a = 1'b1; o.alu_op = 3'b110; o.pc_src = 2'b01; o.pc_write = v.br_pc_write;
            end
            4'd9:  begin o.alu_op = 3'b010; o.src_a = 1'b1; o.src_b = 2'b10; end
            4'd10: begin o.reg_write = 1'b1; end
            4'd11: begin o.pc_src = 2'b10; o.pc_write = 1'b1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic push(input obs_t e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Start at FETCH (posedge + 1), drive one instruction and queue its expected cycles
    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        op    = v.op;
        funct = v.funct;
        zero  = v.zero;
        for (int i = 0; i < v.len; i++) begin
            push(spec_out(v.st[i], v), $sformatf("vec%0d_cyc%0d", idx, i));
        end
        repeat (v.len) @(posedge clk);
        #1;
    endtask

    // Scoreboard check on the falling edge
    always @(negedge clk) begin
        mon_act = {state, aluOp, aluSrcA, aluSrcB, pcSrc, pcWrite, iorD,
                   memWrite, irWrite, regDst, memToReg, regWrite};
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            n_tests++;
            if (mon_act !== mon_exp) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", mon_tag, mon_act, mon_exp);
            end
        end
        n_tests++;
        if ((memWrite & regWrite) !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_exclusive: memWrite=%b regWrite=%b required not both 1",
                     memWrite, regWrite);
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = mkv(6'b100011, 6'b000000, 1'b0, 5, 4'd0, 4'd1, 4'd2,  4'd3,  4'd4, 3'b000, 1'b0, 1'b0);
        vecs[1]  = mkv(6'b101011, 6'b000000, 1'b0, 4, 4'd0, 4'd1, 4'd2,  4'd5,  4'd0, 3'b000, 1'b0, 1'b0);
        vecs[2]  = mkv(6'b000000, 6'b100000, 1'b0, 4, 4'd0, 4'd1, 4'd6,  4'd7,  4'd0, 3'b010, 1'b1, 1'b0);
        vecs[3]  = mkv(6'b000000, 6'b100010, 1'b0, 4, 4'd0, 4'd1, 4'd6,  4'd7,  4'd0, 3'b110, 1'b1, 1'b0);
        vecs[4]  = mkv(6'b000000, 6'b100100, 1'b0, 4, 4'd0, 4'd1, 4'd6,  4'd7,  4'd0, 3'b000, 1'b1, 1'b0);
        vecs[5]  = mkv(6'b000000, 6'b100101, 1'b0, 4, 4'd0, 4'd1, 4'd6,  4'd7,  4'd0, 3'b001, 1'b1, 1'b0);
        vecs[6]  = mkv(6'b000000, 6'b101010, 1'b0, 4, 4'd0, 4'd1, 4'd6,  4'd7,  4'd0, 3'b111, 1'b1, 1'b0);
        vecs[7]  = mkv(6'b000000, 6'b111111, 1'b0, 4, 4'd0, 4'd1, 4'd6,  4'd7,  4'd0, 3'b000, 1'b0, 1'b0);
        vecs[8]  = mkv(6'b000000, 6'b100000, 1'b0, 4, 4'd0, 4'd1, 4'd6,  4'd7,  4'd0, 3'b010, 1'b1, 1'b0);
        vecs[9]  = mkv(6'b000100, 6'b000000, 1'b1, 3, 4'd0, 4'd1, 4'd8,  4'd0,  4'd0, 3'b000, 1'b0, 1'b1);
        vecs[10] = mkv(6'b000100, 6'b000000, 1'b0, 3, 4'd0, 4'd1, 4'd8,  4'd0,  4'd0, 3'b000, 1'b0, 1'b0);
        vecs[11] = mkv(6'b001000, 6'b000000, 1'b0, 4, 4'd0, 4'd1, 4'd9,  4'd10, 4'd0, 3'b000, 1'b0, 1'b0);
        vecs[12] = mkv(6'b000010, 6'b000000, 1'b0, 3, 4'd0, 4'd1, 4'd11, 4'd0,  4'd0, 3'b000, 1'b0, 1'b0);
        vecs[13] = mkv(6'b111111, 6'b000000, 1'b0, 2, 4'd0, 4'd1, 4'd0,  4'd0,  4'd0, 3'b000, 1'b0, 1'b0);
`ifdef MC_CTRL_BNE_EN
        vecs[14] = mkv(6'b000101, 6'b000000, 1'b0, 3, 4'd0, 4'd1, 4'd12, 4'd0,  4'd0, 3'b000, 1'b0, 1'b1);
        vecs[15] = mkv(6'b000101, 6'b000000, 1'b1, 3, 4'd0, 4'd1, 4'd12, 4'd0,  4'd0, 3'b000, 1'b0, 1'b0);
`else
        vecs[14] = mkv(6'b000101, 6'b000000, 1'b0, 2, 4'd0, 4'd1, 4'd0,  4'd0,  4'd0, 3'b000, 1'b0, 1'b0);
        vecs[15] = mkv(6'b000101, 6'b000000, 1'b1, 2, 4'd0, 4'd1, 4'd0,  4'd0,  4'd0, 3'b000, 1'b0, 1'b0);
`endif

        // Reset held for two sampled edges; all outputs and state read 0
        reset = 1'b1;
        op    = 6'b000000;
        funct = 6'b000000;
        zero  = 1'b0;
        @(posedge clk); #1;
        push('0, "reset_c0");
        @(posedge clk); #1;
        push('0, "reset_c1");
        @(posedge clk); #1;
        reset = 1'b0;

        // Instruction table; the first FETCH is the first cycle after release
        for (int i = 0; i < NVEC; i++) begin
            run_vec(i);
        end

        // sw aborted by reset while in MEMADR: next cycle must be FETCH, never MEMWR
        op    = vecs[1].op;
        funct = vecs[1].funct;
        zero  = 1'b0;
        push(spec_out(4'd0, vecs[1]), "abort_fetch");
        push(spec_out(4'd1, vecs[1]), "abort_decode");
        repeat (2) @(posedge clk);
        #1;
        push(spec_out(4'd2, vecs[1]), "abort_memadr");
        @(negedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        run_vec(2);

        // Invalid funct directly followed by a valid one after a j
        run_vec(7);
        run_vec(12);
        run_vec(6);

        @(negedge clk); #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
